// File: rtl/issue_control_if.sv
// Decode/issue handshake bundle between the decode stage and the issue controller.
interface issue_control_if;
  logic        dec_valid;
  logic [3:0]  dec_class;
  logic [3:0]  dec_src1;
  logic [3:0]  dec_src2;
  logic        dec_src1_en;
  logic        dec_src2_en;
  logic [3:0]  dec_dest;
  logic        dec_dest_en;
  logic        flush;
  logic        ld_wb_valid;
  logic [3:0]  ld_wb_dest;
  logic        issue_ready;
  logic        issue_valid;
  logic        mul_busy;
  logic        mul_done;
  logic [3:0]  mul_done_dest;
  logic [15:0] pending;
  logic [15:0] stall_cnt;

  // Decode side: presents uops and load writebacks, observes issue status.
  modport master (
    output dec_valid, dec_class, dec_src1, dec_src2, dec_src1_en, dec_src2_en,
           dec_dest, dec_dest_en, flush, ld_wb_valid, ld_wb_dest,
    input  issue_ready, issue_valid, mul_busy, mul_done, mul_done_dest,
           pending, stall_cnt
  );

  // Issue controller side.
  modport slave (
    input  dec_valid, dec_class, dec_src1, dec_src2, dec_src1_en, dec_src2_en,
           dec_dest, dec_dest_en, flush, ld_wb_valid, ld_wb_dest,
    output issue_ready, issue_valid, mul_busy, mul_done, mul_done_dest,
           pending, stall_cnt
  );
endinterface

// File: rtl/issue_control.sv
// In-order issue control: register scoreboard for RAW/WAW hazards, a single
// multi-cycle multiplier tracked by a small FSM, and a saturating stall counter.
module issue_control #(
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  issue_control_if.slave bus
);

  localparam logic [3:0] LAT = 4'(MUL_LAT);
  localparam logic [3:0] CLS_MUL  = 4'd3;
  localparam logic [3:0] CLS_LOAD = 4'd4;

  typedef enum logic {IDLE, BUSY} mul_state_t;

  mul_state_t  state;
  logic [3:0]  cnt;
  logic        mul_done_q;
  logic [3:0]  mul_dest_q;
  logic [15:0] pending_q;
  logic [15:0] stall_q;

  logic        ready;
  logic        fire;
  logic        is_mul;
  logic        is_ld;
  logic        mul_last;
  logic        stall;
  logic [15:0] pend_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Hazard detection against the registered scoreboard only. The multiplier
  // accepts a new op in its final (mul_done) cycle, so busy blocks only before it.
  always_comb begin
    ready = 1'b1;
    if (bus.dec_src1_en && pending_q[bus.dec_src1]) ready = 1'b0;
    if (bus.dec_src2_en && pending_q[bus.dec_src2]) ready = 1'b0;
    if (bus.dec_dest_en && pending_q[bus.dec_dest]) ready = 1'b0;
    if (bus.dec_class == CLS_MUL && state == BUSY && !mul_done_q) ready = 1'b0;
  end

  assign fire     = bus.dec_valid & ready & ~bus.flush;
  assign is_mul   = fire && (bus.dec_class == CLS_MUL);
  assign is_ld    = fire && (bus.dec_class == CLS_LOAD) && bus.dec_dest_en;
  assign mul_last = (state == BUSY) && (cnt == 4'd1);
  assign stall    = bus.dec_valid & ~ready & ~bus.flush;

  // Scoreboard next state: completions clear first, then a new issue sets.
  always_comb begin
    pend_nxt = pending_q;
    if (mul_last) pend_nxt[mul_dest_q] = 1'b0;
    if (bus.ld_wb_valid) pend_nxt[bus.ld_wb_dest] = 1'b0;
    if (is_mul || is_ld) pend_nxt[bus.dec_dest] = 1'b1;
  end

  // Multiplier FSM; mul_done is high while the counter sits at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      mul_done_q <= 1'b0;
      mul_dest_q <= 4'd0;
    end else if (is_mul) begin
      state      <= BUSY;
      cnt        <= LAT;
      mul_done_q <= (LAT == 4'd1);
      mul_dest_q <= bus.dec_dest;
    end else if (state == BUSY) begin
      if (cnt == 4'd1) begin
        state      <= IDLE;
        cnt        <= 4'd0;
        mul_done_q <= 1'b0;
      end else begin
        cnt        <= cnt - 4'd1;
        mul_done_q <= (cnt == 4'd2);
      end
    end
  end

  // Scoreboard and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 16'd0;
      stall_q   <= 16'd0;
    end else begin
      pending_q <= pend_nxt;
      if (stall) stall_q <= sat_inc(stall_q);
    end
  end

  assign bus.issue_ready   = ready;
  assign bus.issue_valid   = fire;
  assign bus.mul_busy      = (state == BUSY);
  assign bus.mul_done      = mul_done_q;
  assign bus.mul_done_dest = mul_dest_q;
  assign bus.pending       = pending_q;
  assign bus.stall_cnt     = stall_q;

endmodule
